axi_rr_arbiter2: RTL and testbench

Two-to-one AXI4 master arbiter that shares the single CPU-subsystem AXI master port between the AHB-to-AXI bridge output (port s0) and a second requester such as a XOCC DSA data mover (port s1). Write and read paths are arbitrated independently with round-robin priority. Each path carries one outstanding transaction at a time, and the block routes responses to the owner. It sits between the requesters and the wrapper's `m_axi_*` pins; it adds no buffering beyond the owner and state registers.

---
 rtl/axi_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/axi_rr_arbiter2.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_axi_rr_arbiter2.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types for the two-requester AXI4 round-robin arbiter.
// Contents:
//   w_state_t : write-path FSM encoding (W_IDLE, W_BUSY, W_RESP)
//   r_state_t : read-path FSM encoding  (R_IDLE, R_ADDR, R_DATA)
//   owner_t   : 1-bit requester index (0 = s0, 1 = s1)
//   PTR_RESET : last-grant pointer value after reset. It is 1, so s0 wins the first tie.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_BUSY = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    typedef logic owner_t;

    localparam owner_t PTR_RESET = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. This block is purely combinational.
// Ports:
//   req       : request vector, where bit N is requester sN
//   ptr       : requester that won the previous grant on this path
//   gnt_valid : at least one requester is asking
//   winner    : chosen requester; only meaningful when gnt_valid is 1
// On a tie, the requester that did not win last time gets the grant.
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     ptr,
    output logic       gnt_valid,
    output owner_t     winner
);

    always_comb begin
        gnt_valid = |req;
        winner    = 1'b0;
        if (req == 2'b11) begin
            winner = ~ptr;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/axi_rr_arbiter2.sv
// Two-to-one AXI4 master arbiter. Write and read paths arbitrate independently.
// Each path allows one outstanding transaction, and responses are routed back to the owner.
// Ports:
//   i_pad_clk, i_pad_rst : clock, and asynchronous active-high reset
//   s0_*, s1_*           : AW/W/B/AR/R slave-side channels of requesters 0 and 1
//   m_axi_*              : AW/W/B/AR/R master-side channels toward the interconnect
//   o_dbg_*              : write/read FSM state and the write-path done flags
// Handshake rule used on every channel: a transfer happens in a cycle where valid
// and ready are both 1 at the rising clock edge. Valid and ready are only ever
// passed between the owner port and the m_axi port. Non-owner ports see 0.
// Payloads are muxed from the registered owner, so a new request never reaches
// m_axi in the same cycle it is raised.
module axi_rr_arbiter2
    import axi_arb_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_pad_clk,
    input  logic                    i_pad_rst,
    // requester 0
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [ID_WIDTH-1:0]     s0_awid,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [7:0]              s0_awlen,
    input  logic [2:0]              s0_awsize,
    input  logic [1:0]              s0_awburst,
    input  logic [2:0]              s0_awprot,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wlast,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    output logic [ID_WIDTH-1:0]     s0_bid,
    output logic [1:0]              s0_bresp,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    input  logic [ID_WIDTH-1:0]     s0_arid,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    input  logic [2:0]              s0_arprot,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    output logic [ID_WIDTH-1:0]     s0_rid,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rlast,
    // requester 1
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [ID_WIDTH-1:0]     s1_awid,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [7:0]              s1_awlen,
    input  logic [2:0]              s1_awsize,
    input  logic [1:0]              s1_awburst,
    input  logic [2:0]              s1_awprot,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wlast,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    output logic [ID_WIDTH-1:0]     s1_bid,
    output logic [1:0]              s1_bresp,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    input  logic [ID_WIDTH-1:0]     s1_arid,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [7:0]              s1_arlen,
    input  logic [2:0]              s1_arsize,
    input  logic [1:0]              s1_arburst,
    input  logic [2:0]              s1_arprot,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [ID_WIDTH-1:0]     s1_rid,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rlast,
    // shared master port
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [2:0]              m_axi_arprot,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    // debug visibility
    output logic [1:0]              o_dbg_w_state,
    output logic [1:0]              o_dbg_r_state,
    output logic                    o_dbg_aw_done,
    output logic                    o_dbg_w_done
);

    // ---------------- state ----------------
    w_state_t w_state_q, w_state_d;
    owner_t   w_owner_q, w_owner_d;
    owner_t   w_ptr_q,   w_ptr_d;
    logic     aw_done_q, aw_done_d;
    logic     w_done_q,  w_done_d;

    r_state_t r_state_q, r_state_d;
    owner_t   r_owner_q, r_owner_d;
    owner_t   r_ptr_q,   r_ptr_d;

    always_ff @(posedge i_pad_clk or posedge i_pad_rst) begin
        if (i_pad_rst) begin
            w_state_q <= W_IDLE;
            w_owner_q <= 1'b0;
            w_ptr_q   <= PTR_RESET;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            r_state_q <= R_IDLE;
            r_owner_q <= 1'b0;
            r_ptr_q   <= PTR_RESET;
        end else begin
            w_state_q <= w_state_d;
            w_owner_q <= w_owner_d;
            w_ptr_q   <= w_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            r_state_q <= r_state_d;
            r_owner_q <= r_owner_d;
            r_ptr_q   <= r_ptr_d;
        end
    end

    // ---------------- arbitration ----------------
    logic   aw_any, ar_any;
    owner_t aw_win, ar_win;

    rr_arb2 u_aw_arb (
        .req       ({s1_awvalid, s0_awvalid}),
        .ptr       (w_ptr_q),
        .gnt_valid (aw_any),
        .winner    (aw_win)
    );

    rr_arb2 u_ar_arb (
        .req       ({s1_arvalid, s0_arvalid}),
        .ptr       (r_ptr_q),
        .gnt_valid (ar_any),
        .winner    (ar_win)
    );

    // ---------------- write path ----------------
    logic w_sel1, w_busy, w_resp;
    logic aw_open, w_open;
    logic aw_hs, w_last_hs, b_hs;

    assign w_sel1  = (w_owner_q == 1'b1);
    assign w_busy  = (w_state_q == W_BUSY);
    assign w_resp  = (w_state_q == W_RESP);
    // AW and W are each closed off once their part of the burst is done. This lets W
    // finish before AW without a second AW or stray beats leaking to the interconnect.
    assign aw_open = w_busy & ~aw_done_q;
    assign w_open  = w_busy & ~w_done_q;

    assign m_axi_awvalid = aw_open & (w_sel1 ? s1_awvalid : s0_awvalid);
    assign m_axi_awid    = w_sel1 ? s1_awid    : s0_awid;
    assign m_axi_awaddr  = w_sel1 ? s1_awaddr  : s0_awaddr;
    assign m_axi_awlen   = w_sel1 ? s1_awlen   : s0_awlen;
    assign m_axi_awsize  = w_sel1 ? s1_awsize  : s0_awsize;
    assign m_axi_awburst = w_sel1 ? s1_awburst : s0_awburst;
    assign m_axi_awprot  = w_sel1 ? s1_awprot  : s0_awprot;
    assign s0_awready    = aw_open & ~w_sel1 & m_axi_awready;
    assign s1_awready    = aw_open &  w_sel1 & m_axi_awready;

    assign m_axi_wvalid  = w_open & (w_sel1 ? s1_wvalid : s0_wvalid);
    assign m_axi_wdata   = w_sel1 ? s1_wdata : s0_wdata;
    assign m_axi_wstrb   = w_sel1 ? s1_wstrb : s0_wstrb;
    assign m_axi_wlast   = w_sel1 ? s1_wlast : s0_wlast;
    assign s0_wready     = w_open & ~w_sel1 & m_axi_wready;
    assign s1_wready     = w_open &  w_sel1 & m_axi_wready;

    assign m_axi_bready  = w_resp & (w_sel1 ? s1_bready : s0_bready);
    assign s0_bvalid     = w_resp & ~w_sel1 & m_axi_bvalid;
    assign s1_bvalid     = w_resp &  w_sel1 & m_axi_bvalid;
    assign s0_bid        = m_axi_bid;
    assign s1_bid        = m_axi_bid;
    assign s0_bresp      = m_axi_bresp;
    assign s1_bresp      = m_axi_bresp;

    assign aw_hs     = m_axi_awvalid & m_axi_awready;
    assign w_last_hs = m_axi_wvalid & m_axi_wready & m_axi_wlast;
    assign b_hs      = m_axi_bvalid & m_axi_bready;

    always_comb begin
        w_state_d = w_state_q;
        w_owner_d = w_owner_q;
        w_ptr_d   = w_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_any) begin
                    w_owner_d = aw_win;
                    w_ptr_d   = aw_win;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_BUSY;
                end
            end
            W_BUSY: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_last_hs;
                if (aw_done_d && w_done_d) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- read path ----------------
    logic r_sel1, r_addr, r_data;
    logic ar_hs, r_last_hs;

    assign r_sel1 = (r_owner_q == 1'b1);
    assign r_addr = (r_state_q == R_ADDR);
    assign r_data = (r_state_q == R_DATA);

    assign m_axi_arvalid = r_addr & (r_sel1 ? s1_arvalid : s0_arvalid);
    assign m_axi_arid    = r_sel1 ? s1_arid    : s0_arid;
    assign m_axi_araddr  = r_sel1 ? s1_araddr  : s0_araddr;
    assign m_axi_arlen   = r_sel1 ? s1_arlen   : s0_arlen;
    assign m_axi_arsize  = r_sel1 ? s1_arsize  : s0_arsize;
    assign m_axi_arburst = r_sel1 ? s1_arburst : s0_arburst;
    assign m_axi_arprot  = r_sel1 ? s1_arprot  : s0_arprot;
    assign s0_arready    = r_addr & ~r_sel1 & m_axi_arready;
    assign s1_arready    = r_addr &  r_sel1 & m_axi_arready;

    assign m_axi_rready  = r_data & (r_sel1 ? s1_rready : s0_rready);
    assign s0_rvalid     = r_data & ~r_sel1 & m_axi_rvalid;
    assign s1_rvalid     = r_data &  r_sel1 & m_axi_rvalid;
    assign s0_rid        = m_axi_rid;
    assign s1_rid        = m_axi_rid;
    assign s0_rdata      = m_axi_rdata;
    assign s1_rdata      = m_axi_rdata;
    assign s0_rresp      = m_axi_rresp;
    assign s1_rresp      = m_axi_rresp;
    assign s0_rlast      = m_axi_rlast;
    assign s1_rlast      = m_axi_rlast;

    assign ar_hs     = m_axi_arvalid & m_axi_arready;
    assign r_last_hs = m_axi_rvalid & m_axi_rready & m_axi_rlast;

    always_comb begin
        r_state_d = r_state_q;
        r_owner_d = r_owner_q;
        r_ptr_d   = r_ptr_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_any) begin
                    r_owner_d = ar_win;
                    r_ptr_d   = ar_win;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_last_hs) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---------------- debug ----------------
    assign o_dbg_w_state = w_state_q;
    assign o_dbg_r_state = r_state_q;
    assign o_dbg_aw_done = aw_done_q;
    assign o_dbg_w_done  = w_done_q;

endmodule

// File: tb/tb_axi_rr_arbiter2.sv
module tb_axi_rr_arbiter2;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic s0_awvalid, s0_awready, s1_awvalid, s1_awready;
  logic [IDW-1:0] s0_awid, s1_awid, s0_bid, s1_bid, s0_arid, s1_arid, s0_rid, s1_rid;
  logic [AW-1:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr;
  logic [7:0] s0_awlen, s1_awlen, s0_arlen, s1_arlen;
  logic [2:0] s0_awsize, s1_awsize, s0_awprot, s1_awprot, s0_arsize, s1_arsize, s0_arprot, s1_arprot;
  logic [1:0] s0_awburst, s1_awburst, s0_arburst, s1_arburst, s0_bresp, s1_bresp, s0_rresp, s1_rresp;
  logic s0_wvalid, s0_wready, s0_wlast, s1_wvalid, s1_wready, s1_wlast;
  logic [DW-1:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata;
  logic [SW-1:0] s0_wstrb, s1_wstrb;
  logic s0_bvalid, s0_bready, s1_bvalid, s1_bready;
  logic s0_arvalid, s0_arready, s1_arvalid, s1_arready;
  logic s0_rvalid, s0_rready, s0_rlast, s1_rvalid, s1_rready, s1_rlast;

  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [IDW-1:0] m_awid, m_bid, m_arid, m_rid;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_awprot, m_arsize, m_arprot;
  logic [1:0] m_awburst, m_arburst, m_bresp, m_rresp;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic [1:0] dbg_w_state, dbg_r_state;
  logic dbg_aw_done, dbg_w_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_rr_arbiter2 #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_pad_clk(clk), .i_pad_rst(rst),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awid(s0_awid), .s0_awaddr(s0_awaddr),
    .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst), .s0_awprot(s0_awprot),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bid(s0_bid), .s0_bresp(s0_bresp),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_arid(s0_arid), .s0_araddr(s0_araddr),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arprot(s0_arprot),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
    .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awid(s1_awid), .s1_awaddr(s1_awaddr),
    .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst), .s1_awprot(s1_awprot),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bid(s1_bid), .s1_bresp(s1_bresp),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_arid(s1_arid), .s1_araddr(s1_araddr),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arprot(s1_arprot),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
    .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready), .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr),
    .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awprot(m_awprot),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wlast(m_wlast), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_bid(m_bid),
    .m_axi_bresp(m_bresp), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_arid(m_arid),
    .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
    .m_axi_arprot(m_arprot), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .m_axi_rid(m_rid),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .o_dbg_w_state(dbg_w_state), .o_dbg_r_state(dbg_r_state),
    .o_dbg_aw_done(dbg_aw_done), .o_dbg_w_done(dbg_w_done)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    s0_awvalid = 0; s0_awid = '0; s0_awaddr = '0; s0_awlen = '0; s0_awsize = 3'd2; s0_awburst = 2'd1; s0_awprot = '0;
    s1_awvalid = 0; s1_awid = '0; s1_awaddr = '0; s1_awlen = '0; s1_awsize = 3'd2; s1_awburst = 2'd1; s1_awprot = '0;
    s0_wvalid = 0; s0_wdata = '0; s0_wstrb = '1; s0_wlast = 0; s0_bready = 0;
    s1_wvalid = 0; s1_wdata = '0; s1_wstrb = '1; s1_wlast = 0; s1_bready = 0;
    s0_arvalid = 0; s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd2; s0_arburst = 2'd1; s0_arprot = '0;
    s1_arvalid = 0; s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd2; s1_arburst = 2'd1; s1_arprot = '0;
    s0_rready = 0; s1_rready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = '0; m_bresp = '0;
    m_arready = 0; m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
  endtask

  task automatic apply_reset();
    idle_all();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  // Concatenation of every valid/ready output the block drives.
  function automatic logic [15:0] all_handshake_outs();
    return {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
            s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid,
            s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid, 1'b0};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_all();
    rst = 1;
    // Upstream and downstream both asserting: outputs must still be quiet under reset.
    s0_awvalid = 1; s1_arvalid = 1; m_awready = 1; m_wready = 1; m_bvalid = 1; m_rvalid = 1;
    s0_bready = 1; s1_rready = 1; s0_wvalid = 1;
    step();
    checks++;
    if (all_handshake_outs() !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0000", all_handshake_outs());
    end
    checks++;
    if ({dbg_w_state, dbg_r_state} !== 4'b0000) begin
      errors++; $display("FAIL reset_states: got %b exp 0000", {dbg_w_state, dbg_r_state});
    end
    apply_reset();
  endtask

  task automatic test_solo_write();
    apply_reset();
    s0_awvalid = 1; s0_awid = 4'h5; s0_awaddr = 32'h8000_0010; s0_awlen = 8'd3;
    #1;
    checks++;
    if (m_awvalid !== 1'b0) begin
      errors++; $display("FAIL solo_no_comb_grant: got %b exp 0", m_awvalid);
    end
    step();
    checks++;
    if ({m_awvalid, m_awid, m_awaddr, m_awlen} !== {1'b1, 4'h5, 32'h8000_0010, 8'd3}) begin
      errors++; $display("FAIL solo_aw_fwd: got v=%b id=%h a=%h l=%0d exp v=1 id=5 a=80000010 l=3",
                         m_awvalid, m_awid, m_awaddr, m_awlen);
    end
    m_awready = 1;
    #1;
    checks++;
    if ({s0_awready, s1_awready} !== 2'b10) begin
      errors++; $display("FAIL solo_awready: got %b exp 10", {s0_awready, s1_awready});
    end
    step();
    s0_awvalid = 0; m_awready = 0; m_wready = 1;
    for (int i = 0; i < 4; i++) begin
      s0_wvalid = 1; s0_wdata = 32'hA0 + i; s0_wlast = (i == 3);
      #1;
      checks++;
      if ({m_wvalid, m_wdata, m_wlast, s0_wready, s1_wready} !== {1'b1, 32'hA0 + i, (i == 3), 1'b1, 1'b0}) begin
        errors++; $display("FAIL solo_w_beat%0d: got v=%b d=%h l=%b r0=%b r1=%b exp v=1 d=%h",
                           i, m_wvalid, m_wdata, m_wlast, s0_wready, s1_wready, 32'hA0 + i);
      end
      step();
    end
    s0_wvalid = 0; s0_wlast = 0; m_wready = 0;
    checks++;
    if (dbg_w_state !== 2'd2) begin
      errors++; $display("FAIL solo_to_resp: got %0d exp 2", dbg_w_state);
    end
    m_bvalid = 1; m_bid = 4'h5; m_bresp = 2'b00; s0_bready = 1;
    #1;
    checks++;
    if ({s0_bvalid, s1_bvalid, s0_bid, s0_bresp, m_bready} !== {1'b1, 1'b0, 4'h5, 2'b00, 1'b1}) begin
      errors++; $display("FAIL solo_b_route: got b0=%b b1=%b id=%h resp=%b rdy=%b exp 1 0 5 00 1",
                         s0_bvalid, s1_bvalid, s0_bid, s0_bresp, m_bready);
    end
    step();
    m_bvalid = 0; s0_bready = 0;
    checks++;
    if (dbg_w_state !== 2'd0) begin
      errors++; $display("FAIL solo_to_idle: got %0d exp 0", dbg_w_state);
    end
  endtask

  task automatic test_write_contention();
    logic exp_own;
    apply_reset();
    s0_awvalid = 1; s0_awid = 4'h1; s1_awvalid = 1; s1_awid = 4'h2;
    s0_wvalid = 1; s0_wlast = 1; s1_wvalid = 1; s1_wlast = 1;
    s0_bready = 1; s1_bready = 1;
    m_awready = 1; m_wready = 1; m_bvalid = 1;
    for (int g = 0; g < 4; g++) begin
      exp_own = g[0];
      step();
      checks++;
      if ({dbg_w_state, m_awvalid, m_awid} !== {2'd1, 1'b1, (exp_own ? 4'h2 : 4'h1)}) begin
        errors++; $display("FAIL contention_grant%0d: got st=%0d v=%b id=%h exp st=1 v=1 id=%0d",
                           g, dbg_w_state, m_awvalid, m_awid, exp_own ? 2 : 1);
      end
      step();
      checks++;
      if ({dbg_w_state, s1_bvalid, s0_bvalid} !== {2'd2, exp_own, ~exp_own}) begin
        errors++; $display("FAIL contention_resp%0d: got st=%0d b1=%b b0=%b exp owner=%b",
                           g, dbg_w_state, s1_bvalid, s0_bvalid, exp_own);
      end
      step();
      checks++;
      if ({dbg_w_state, m_awvalid} !== {2'd0, 1'b0}) begin
        errors++; $display("FAIL contention_turnaround%0d: got st=%0d v=%b exp st=0 v=0",
                           g, dbg_w_state, m_awvalid);
      end
    end
    idle_all();
  endtask

  task automatic test_w_before_aw();
    apply_reset();
    s1_awvalid = 1; s1_awid = 4'h3; s1_wvalid = 1; s1_wlast = 1; s1_wdata = 32'h55;
    m_wready = 1;
    step();
    checks++;
    if ({m_awvalid, m_wvalid, m_wdata, s1_wready, s0_wready} !== {1'b1, 1'b1, 32'h55, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wfirst_fwd: got aw=%b w=%b d=%h r1=%b r0=%b exp 1 1 55 1 0",
                         m_awvalid, m_wvalid, m_wdata, s1_wready, s0_wready);
    end
    step();
    s1_wvalid = 0; s1_wlast = 0; m_wready = 0;
    #1;
    checks++;
    if ({dbg_w_done, dbg_aw_done, m_wvalid, dbg_w_state} !== {1'b1, 1'b0, 1'b0, 2'd1}) begin
      errors++; $display("FAIL wfirst_wdone: got wd=%b ad=%b wv=%b st=%0d exp 1 0 0 1",
                         dbg_w_done, dbg_aw_done, m_wvalid, dbg_w_state);
    end
    step();
    m_awready = 1;
    #1;
    checks++;
    if ({s1_awready, s0_awready} !== 2'b10) begin
      errors++; $display("FAIL wfirst_awready: got %b exp 10", {s1_awready, s0_awready});
    end
    step();
    s1_awvalid = 0; m_awready = 0;
    checks++;
    if ({dbg_w_state, dbg_aw_done} !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL wfirst_to_resp: got st=%0d ad=%b exp 2 1", dbg_w_state, dbg_aw_done);
    end
    m_bvalid = 1; m_bid = 4'h3; m_bresp = 2'b00; s1_bready = 1;
    #1;
    checks++;
    if ({s1_bvalid, s0_bvalid, s1_bid} !== {1'b1, 1'b0, 4'h3}) begin
      errors++; $display("FAIL wfirst_b_route: got b1=%b b0=%b id=%h exp 1 0 3", s1_bvalid, s0_bvalid, s1_bid);
    end
    step();
    idle_all();
    checks++;
    if (dbg_w_state !== 2'd0) begin
      errors++; $display("FAIL wfirst_idle: got %0d exp 0", dbg_w_state);
    end
  endtask

  task automatic test_concurrent();
    apply_reset();
    s0_arvalid = 1; s0_arid = 4'h6; s0_arlen = 8'd7; s0_araddr = 32'h1000;
    s1_awvalid = 1; s1_awid = 4'h2; s1_awlen = 8'd0; s1_wvalid = 1; s1_wlast = 1;
    m_arready = 1; m_awready = 1; m_wready = 1;
    step();
    checks++;
    if ({dbg_r_state, m_arvalid, m_arlen, m_arid, dbg_w_state, m_awid} !==
        {2'd1, 1'b1, 8'd7, 4'h6, 2'd1, 4'h2}) begin
      errors++; $display("FAIL concur_grants: got rs=%0d arv=%b len=%0d arid=%h ws=%0d awid=%h exp 1 1 7 6 1 2",
                         dbg_r_state, m_arvalid, m_arlen, m_arid, dbg_w_state, m_awid);
    end
    step();
    s0_arvalid = 0; s1_awvalid = 0; s1_wvalid = 0; s1_wlast = 0;
    m_arready = 0; m_awready = 0; m_wready = 0;
    checks++;
    if ({dbg_r_state, dbg_w_state} !== {2'd2, 2'd2}) begin
      errors++; $display("FAIL concur_simul: got rs=%0d ws=%0d exp 2 2", dbg_r_state, dbg_w_state);
    end
    m_bvalid = 1; m_bid = 4'h2; s1_bready = 1; s0_rready = 1;
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 1; m_rid = 4'h6; m_rdata = 32'h100 + i; m_rlast = (i == 7);
      #1;
      checks++;
      if ({s0_rvalid, s1_rvalid, s0_rdata, s0_rid} !== {1'b1, 1'b0, 32'h100 + i, 4'h6}) begin
        errors++; $display("FAIL concur_r_beat%0d: got r0=%b r1=%b d=%h id=%h exp 1 0 %h 6",
                           i, s0_rvalid, s1_rvalid, s0_rdata, s0_rid, 32'h100 + i);
      end
      if (i == 0) begin
        checks++;
        if ({s1_bvalid, s0_bvalid} !== 2'b10) begin
          errors++; $display("FAIL concur_b_route: got %b exp 10", {s1_bvalid, s0_bvalid});
        end
      end
      step();
      m_bvalid = 0; s1_bready = 0;
    end
    m_rvalid = 0; m_rlast = 0;
    checks++;
    if ({dbg_r_state, dbg_w_state} !== 4'b0000) begin
      errors++; $display("FAIL concur_done: got rs=%0d ws=%0d exp 0 0", dbg_r_state, dbg_w_state);
    end
    idle_all();
  endtask

  task automatic test_resp_routing();
    logic [1:0] exp_resp;
    apply_reset();
    s1_arvalid = 1; s1_arid = 4'h9; s1_arlen = 8'd3; m_arready = 1;
    step();
    step();
    s1_arvalid = 0; m_arready = 0; s1_rready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_resp = (i == 2) ? 2'b10 : 2'b00;
      m_rvalid = 1; m_rid = 4'h9; m_rresp = exp_resp; m_rlast = (i == 3); m_rdata = 32'hC0 + i;
      #1;
      checks++;
      if ({s1_rvalid, s1_rresp, s1_rid, s0_rvalid, s0_arready, s0_bvalid} !==
          {1'b1, exp_resp, 4'h9, 1'b0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL route_beat%0d: got r1=%b resp=%b id=%h r0=%b ar0=%b b0=%b exp resp=%b",
                           i, s1_rvalid, s1_rresp, s1_rid, s0_rvalid, s0_arready, s0_bvalid, exp_resp);
      end
      step();
    end
    idle_all();
    checks++;
    if (dbg_r_state !== 2'd0) begin
      errors++; $display("FAIL route_idle: got %0d exp 0", dbg_r_state);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    s0_arvalid = 1; s0_arid = 4'h4; s0_arlen = 8'd3; m_arready = 1;
    step();
    step();
    s0_arvalid = 0; m_arready = 0; s0_rready = 1;
    for (int i = 0; i < 2; i++) begin
      m_rvalid = 1; m_rdata = 32'hD0 + i;
      step();
    end
    m_rdata = 32'hD2;
    #1;
    checks++;
    if ({s0_rvalid, m_rready} !== 2'b11) begin
      errors++; $display("FAIL midrst_before: got rv=%b rr=%b exp 1 1", s0_rvalid, m_rready);
    end
    rst = 1;
    #1;
    checks++;
    if (all_handshake_outs() !== 16'h0 || dbg_r_state !== 2'd0) begin
      errors++; $display("FAIL midrst_async_clear: got %h rs=%0d exp 0000 0", all_handshake_outs(), dbg_r_state);
    end
    idle_all();
    step();
    rst = 0;
    s1_arvalid = 1; s1_arid = 4'hB;
    #1;
    checks++;
    if (m_arvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_no_comb: got %b exp 0", m_arvalid);
    end
    step();
    checks++;
    if ({m_arvalid, m_arid, dbg_r_state} !== {1'b1, 4'hB, 2'd1}) begin
      errors++; $display("FAIL midrst_regrant: got v=%b id=%h rs=%0d exp 1 b 1", m_arvalid, m_arid, dbg_r_state);
    end
    idle_all();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_all();
    test_reset();
    test_solo_write();
    test_write_contention();
    test_w_before_aw();
    test_concurrent();
    test_resp_routing();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
